// File: rtl/rr_burst_xfer.sv
// Burst mover behind a 4-way round-robin arbiter. It samples a one-hot grant while idle,
// streams len+1 beats from the granted source over valid/ready, then holds off for a short gap.
module rr_burst_xfer #(
    parameter int DATA_W  = 8,
    parameter int LEN_W   = 4,
    parameter int GAP_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            gnt,
    input  logic [3:0]            req_in,
    input  logic [4*DATA_W-1:0]   src_data,
    input  logic [4*LEN_W-1:0]    src_len,
    output logic [3:0]            src_pop,
    output logic [3:0]            src_done,
    output logic                  m_valid,
    output logic [DATA_W-1:0]     m_data,
    output logic                  m_last,
    output logic [1:0]            m_src,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  gnt_err
);

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t             r_state, w_state_nx;
    logic [1:0]         r_idx, w_idx_nx;
    logic [LEN_W-1:0]   r_len, w_len_nx;
    logic [LEN_W-1:0]   r_beat_cnt, w_beat_nx;
    logic [GAP_W-1:0]   r_gap_cnt, w_gap_nx;
    logic [3:0]         r_done, w_done_nx;
    logic               r_gnt_err, w_err_nx;

    logic               w_gnt_onehot;
    logic [1:0]         w_gnt_idx;
    logic               w_xfer;
    logic               w_hs;
    logic               w_at_last;
    logic [3:0]         w_idx_oh;

    // A grant is usable only if exactly one bit is set.
    assign w_gnt_onehot = (gnt != 4'd0) && ((gnt & (gnt - 4'd1)) == 4'd0);

    always_comb begin
        w_gnt_idx = 2'd0;
        case (gnt)
            4'b0010: w_gnt_idx = 2'd1;
            4'b0100: w_gnt_idx = 2'd2;
            4'b1000: w_gnt_idx = 2'd3;
            default: w_gnt_idx = 2'd0;
        endcase
    end

    assign w_xfer    = (r_state == ST_XFER);
    assign w_hs      = w_xfer && m_ready;
    assign w_at_last = (r_beat_cnt == r_len);
    assign w_idx_oh  = 4'b0001 << r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= 2'd0;
            r_len      <= '0;
            r_beat_cnt <= '0;
            r_gap_cnt  <= '0;
            r_done     <= 4'd0;
            r_gnt_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_idx      <= w_idx_nx;
            r_len      <= w_len_nx;
            r_beat_cnt <= w_beat_nx;
            r_gap_cnt  <= w_gap_nx;
            r_done     <= w_done_nx;
            r_gnt_err  <= w_err_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_len_nx   = r_len;
        w_beat_nx  = r_beat_cnt;
        w_gap_nx   = r_gap_cnt;
        w_done_nx  = 4'd0;
        w_err_nx   = r_gnt_err;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_onehot) begin
                    // Stale grants (requester already dropped) are ignored.
                    if ((gnt & req_in) != 4'd0) begin
                        w_idx_nx   = w_gnt_idx;
                        w_len_nx   = src_len[w_gnt_idx*LEN_W +: LEN_W];
                        w_beat_nx  = '0;
                        w_state_nx = ST_XFER;
                    end
                end else if (gnt != 4'd0) begin
                    w_err_nx = 1'b1;
                end
            end
            ST_XFER: begin
                if (w_hs) begin
                    if (w_at_last) begin
                        w_done_nx  = w_idx_oh;
                        w_gap_nx   = GAP_W'(GAP_CYC - 1);
                        w_state_nx = ST_GAP;
                    end else begin
                        w_beat_nx = r_beat_cnt + LEN_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_gap_nx = r_gap_cnt - GAP_W'(1);
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    assign m_valid  = w_xfer;
    assign m_data   = w_xfer ? src_data[r_idx*DATA_W +: DATA_W] : '0;
    assign m_last   = w_xfer && w_at_last;
    assign m_src    = r_idx;
    assign src_pop  = w_hs ? w_idx_oh : 4'd0;
    assign src_done = r_done;
    assign busy     = (r_state != ST_IDLE);
    assign gnt_err  = r_gnt_err;

endmodule

// File: tb/tb_rr_burst_xfer.sv
// Scoreboard bench for rr_burst_xfer: stimulus queues expected beats/done pulses,
// a negedge monitor pops and compares whenever the DUT presents a beat or a done pulse.
module tb_rr_burst_xfer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  gnt;
    logic [3:0]  req_in;
    logic [31:0] src_data;
    logic [15:0] src_len;
    logic [3:0]  src_pop;
    logic [3:0]  src_done;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_last;
    logic [1:0]  m_src;
    logic        m_ready;
    logic        busy;
    logic        gnt_err;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [1:0] src;
    } beat_t;

    beat_t      sb_q[$];
    logic [3:0] done_q[$];
    logic [3:0] pend_pop = 4'd0;
    logic       done_due = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;

    rr_burst_xfer #(.DATA_W(8), .LEN_W(4), .GAP_CYC(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .gnt      (gnt),
        .req_in   (req_in),
        .src_data (src_data),
        .src_len  (src_len),
        .src_pop  (src_pop),
        .src_done (src_done),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_last   (m_last),
        .m_src    (m_src),
        .m_ready  (m_ready),
        .busy     (busy),
        .gnt_err  (gnt_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares presented beats against the queue head, pops on handshake.
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            done_due = 1'b0;
            pend_pop = 4'd0;
        end else begin
            if (done_due) begin
                if (done_q.size() == 0) chk("src_done_unqueued", 32'(src_done), 32'd0);
                else                    chk("src_done", 32'(src_done), 32'(done_q.pop_front()));
            end else if (src_done != 4'd0) begin
                chk("src_done_spurious", 32'(src_done), 32'd0);
            end
            done_due = 1'b0;
            if (m_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_valid", 32'(m_valid), 32'd0);
                end else begin
                    e = sb_q[0];
                    chk("m_data", 32'(m_data), 32'(e.data));
                    chk("m_last", 32'(m_last), 32'(e.last));
                    chk("m_src",  32'(m_src),  32'(e.src));
                    if (m_ready) begin
                        chk("src_pop", 32'(src_pop), 32'(4'b0001 << e.src));
                        sb_q.delete(0);
                        pend_pop = src_pop;
                        done_due = e.last;
                    end else begin
                        chk("src_pop_stall", 32'(src_pop), 32'd0);
                    end
                end
            end else if (src_pop != 4'd0) begin
                chk("src_pop_idle", 32'(src_pop), 32'd0);
            end
        end
    end

    // Source model: each popped head-of-queue advances to the next payload.
    always begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (pend_pop[i]) src_data[i*8 +: 8] = src_data[i*8 +: 8] + 8'd1;
        pend_pop = 4'd0;
    end

    task automatic push_burst(input int i, input int len);
        logic [7:0] d0;
        beat_t      b;
        d0 = src_data[i*8 +: 8];
        for (int k = 0; k <= len; k++) begin
            b.data = d0 + 8'(k);
            b.last = (k == len);
            b.src  = 2'(i);
            sb_q.push_back(b);
        end
        done_q.push_back(4'(1 << i));
    endtask

    task automatic start_burst(input int i, input int len);
        push_burst(i, len);
        src_len[i*4 +: 4] = 4'(len);
        gnt    = 4'(1 << i);
        req_in = 4'(1 << i);
        tick();
        gnt    = 4'd0;
        req_in = 4'd0;
        chk("latency_valid", 32'(m_valid), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while ((sb_q.size() != 0 || done_q.size() != 0 || busy) && c < budget) begin
            tick();
            c++;
        end
        if (c >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_idle: timed out after %0d cycles, %0d beats pending", c, sb_q.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ptr;
        int ndone;
        logic bp_pat [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        rst_n    = 1'b0;
        gnt      = 4'd0;
        req_in   = 4'd0;
        src_data = {8'h40, 8'h30, 8'h20, 8'h10};
        src_len  = 16'd0;
        m_ready  = 1'b0;
        tick();
        tick();
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_gnt_err", 32'(gnt_err), 32'd0);
        chk("rst_done",    32'(src_done), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single burst, 4 beats at full rate, then two gap cycles.
        m_ready = 1'b1;
        start_burst(1, 3);
        repeat (4) tick();
        chk("gap_busy_1", 32'(busy), 32'd1);
        tick();
        chk("gap_busy_2", 32'(busy), 32'd1);
        tick();
        chk("gap_end_busy", 32'(busy), 32'd0);
        wait_idle(20);

        // Backpressure: 2-beat burst under a stalling sink.
        m_ready = 1'b0;
        start_burst(2, 1);
        for (int k = 0; k < 5; k++) begin
            m_ready = bp_pat[k];
            chk("bp_valid_held", 32'(m_valid), 32'd1);
            tick();
        end
        m_ready = 1'b1;
        wait_idle(20);

        // Rotation: everyone requesting, arbiter advances after each completion.
        src_len = 16'd0;
        for (int i = 0; i < 4; i++) push_burst(i, 0);
        req_in = 4'b1111;
        ptr    = 0;
        ndone  = 0;
        gnt    = 4'b0001;
        for (int c = 0; c < 60 && ndone < 4; c++) begin
            tick();
            if (src_done != 4'd0) begin
                ndone++;
                if (ndone == 4) begin
                    gnt    = 4'd0;
                    req_in = 4'd0;
                end else begin
                    ptr++;
                    gnt = 4'(1 << ptr);
                end
            end
        end
        gnt    = 4'd0;
        req_in = 4'd0;
        wait_idle(20);

        // Stale then illegal grants.
        gnt    = 4'b0100;
        req_in = 4'b0000;
        tick();
        tick();
        chk("stale_busy",    32'(busy),    32'd0);
        chk("stale_valid",   32'(m_valid), 32'd0);
        chk("stale_gnt_err", 32'(gnt_err), 32'd0);
        gnt    = 4'b0110;
        req_in = 4'b0110;
        tick();
        chk("illegal_gnt_err", 32'(gnt_err), 32'd1);
        chk("illegal_busy",    32'(busy),    32'd0);
        gnt    = 4'd0;
        req_in = 4'd0;
        tick();
        tick();
        chk("gnt_err_sticky", 32'(gnt_err), 32'd1);

        // Maximum length: 16 beats, last only on the final one.
        start_burst(0, 15);
        wait_idle(40);

        // Reset while the second beat is on the bus.
        start_burst(3, 5);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rr_m_valid",  32'(m_valid),  32'd0);
        chk("rr_m_data",   32'(m_data),   32'd0);
        chk("rr_m_last",   32'(m_last),   32'd0);
        chk("rr_m_src",    32'(m_src),    32'd0);
        chk("rr_src_pop",  32'(src_pop),  32'd0);
        chk("rr_src_done", 32'(src_done), 32'd0);
        chk("rr_busy",     32'(busy),     32'd0);
        chk("rr_gnt_err",  32'(gnt_err),  32'd0);
        sb_q.delete();
        done_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("rr_no_done", 32'(src_done), 32'd0);
        start_burst(3, 2);
        wait_idle(20);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
